// File: rtl/dfe_cfg_sequencer_pkg.sv
// Address map, CTRL word layout and FSM state type shared by the DFE configuration sequencer.
package dfe_cfg_pkg;

  localparam int ADDR_W     = 7;
  localparam int FRAC_BASE  = 0;
  localparam int FRAC_DEPTH = 72;
  localparam int IIR_DEPTH  = 5;
  localparam int IIR1_BASE  = FRAC_BASE + FRAC_DEPTH;
  localparam int IIR2_BASE  = IIR1_BASE + IIR_DEPTH;
  localparam int IIR24_BASE = IIR2_BASE + IIR_DEPTH;
  localparam int CTRL_ADDR  = IIR24_BASE + IIR_DEPTH;

  // CTRL word bit positions; the decimation factor field starts at CTRL_DEC_LSB
  localparam int CTRL_FRAC_BYP  = 0;
  localparam int CTRL_IIR5M_BYP = 1;
  localparam int CTRL_IIR24_BYP = 2;
  localparam int CTRL_CIC_BYP   = 3;
  localparam int CTRL_DEC_LSB   = 4;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY,
    DONE
  } cfg_state_e;

  function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
    return int'(addr) <= CTRL_ADDR;
  endfunction

endpackage

// File: rtl/dfe_cfg_sequencer_if.sv
// Valid/ready configuration write port with commit request.
interface dfe_cfg_sequencer_if #(
  parameter int COEFF_WIDTH = 20
) ();
  import dfe_cfg_pkg::*;

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [ADDR_W-1:0]      cfg_addr;
  logic [COEFF_WIDTH-1:0] cfg_data;
  logic                   cfg_commit;

  modport master (output cfg_valid, cfg_addr, cfg_data, cfg_commit, input cfg_ready);
  modport slave  (input cfg_valid, cfg_addr, cfg_data, cfg_commit, output cfg_ready);

endinterface

// File: rtl/dfe_cfg_sequencer_coeff_bank.sv
// One coefficient bank: staging words, dirty flag, and output words loaded on apply.
module cfg_coeff_bank
  import dfe_cfg_pkg::*;
#(
  parameter int COEFF_WIDTH = 20,
  parameter int DEPTH       = 5,
  parameter int BASE        = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [COEFF_WIDTH-1:0]        data_i,
  input  logic                          apply_i,
  output logic                          wr_en_o,
  output logic signed [COEFF_WIDTH-1:0] coeff_o [DEPTH]
);

  logic signed [COEFF_WIDTH-1:0] stage_q [DEPTH];
  logic signed [COEFF_WIDTH-1:0] out_q   [DEPTH];
  logic                          dirty_q;
  logic                          wr_en_q;
  logic                          hit;
  logic [ADDR_W-1:0]             offset;

  assign offset = addr_i - ADDR_W'(BASE);
  assign hit    = wr_i && (int'(addr_i) >= BASE) && (int'(addr_i) < BASE + DEPTH);

  // NOTE: these arrays are plain flops rather than a RAM, so they can and do take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
        out_q[k]   <= '0;
      end
      dirty_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking, so the apply below copies the staging values from before this edge.
      wr_en_q <= apply_i && dirty_q;
      if (apply_i && dirty_q) begin
        for (int k = 0; k < DEPTH; k++) out_q[k] <= stage_q[k];
        dirty_q <= 1'b0;
      end
      if (hit) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (offset == ADDR_W'(k)) stage_q[k] <= data_i;
        end
        dirty_q <= 1'b1;
      end
    end
  end

  assign wr_en_o = wr_en_q;
  assign coeff_o = out_q;

endmodule

// File: rtl/dfe_cfg_sequencer.sv
// Stages DFE coefficient/control writes and applies all dirty banks in one cycle inside a core input gap.
module dfe_cfg_sequencer
  import dfe_cfg_pkg::*;
#(
  parameter int COEFF_WIDTH = 20,
  parameter int N_TAP       = 72,
  parameter int COEFF_DEPTH = 5,
  parameter int DEC_WIDTH   = 4,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  dfe_cfg_sequencer_if.slave            cfg,
  input  logic                          core_valid_in,
  output logic                          commit_done,
  output logic                          commit_late,
  output logic                          addr_err,
  output logic signed [COEFF_WIDTH-1:0] frac_coeff     [N_TAP],
  output logic signed [COEFF_WIDTH-1:0] iir_coeff_1m   [COEFF_DEPTH],
  output logic signed [COEFF_WIDTH-1:0] iir_coeff_2m   [COEFF_DEPTH],
  output logic signed [COEFF_WIDTH-1:0] iir_coeff_2_4m [COEFF_DEPTH],
  output logic                          frac_wr_en,
  output logic                          iir_wr_en_1m,
  output logic                          iir_wr_en_2m,
  output logic                          iir_wr_en_2_4m,
  output logic                          frac_bypass,
  output logic                          iir_bypass_5m,
  output logic                          iir_bypass_2_4m,
  output logic                          cic_bypass,
  output logic [DEC_WIDTH:0]            cic_dec_factor
);

  localparam int GAP_W  = $clog2(GAP_TIMEOUT + 1);
  localparam int DEC_W  = DEC_WIDTH + 1;
  localparam int CTRL_W = CTRL_DEC_LSB + DEC_W;

  cfg_state_e       state_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             ready_q;
  logic             done_q;
  logic             late_q;
  logic             addr_err_q;

  logic             wr_acc;
  logic             commit_acc;
  logic             apply_go;

  assign wr_acc     = cfg.cfg_valid && ready_q;
  assign commit_acc = cfg.cfg_commit && ready_q;
  // Leave PENDING on the first idle core cycle, or force it once the gap budget is spent
  assign apply_go   = (state_q == PENDING) &&
                      (!core_valid_in || (gap_cnt_q == GAP_W'(GAP_TIMEOUT - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      late_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (commit_acc) begin
            state_q   <= PENDING;
            ready_q   <= 1'b0;
            gap_cnt_q <= '0;
            late_q    <= 1'b0;
          end
        end
        PENDING: begin
          if (apply_go) begin
            state_q <= APPLY;
            late_q  <= core_valid_in;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        APPLY: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      // A bad write in the commit cycle itself stays reported for the next round
      if (commit_acc) addr_err_q <= 1'b0;
      if (wr_acc && !addr_mapped(cfg.cfg_addr)) addr_err_q <= 1'b1;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign commit_done   = done_q;
  assign commit_late   = late_q;
  assign addr_err      = addr_err_q;

  logic [CTRL_W-1:0] ctrl_stage_q;
  logic              ctrl_dirty_q;
  logic              frac_byp_q;
  logic              iir5m_byp_q;
  logic              iir24_byp_q;
  logic              cic_byp_q;
  logic [DEC_W-1:0]  dec_q;
  logic [DEC_W-1:0]  dec_staged;

  assign dec_staged = ctrl_stage_q[CTRL_DEC_LSB +: DEC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_stage_q <= '0;
      ctrl_dirty_q <= 1'b0;
      frac_byp_q   <= 1'b1;
      iir5m_byp_q  <= 1'b1;
      iir24_byp_q  <= 1'b1;
      cic_byp_q    <= 1'b1;
      dec_q        <= DEC_W'(1);
    end else begin
      if (wr_acc && (int'(cfg.cfg_addr) == CTRL_ADDR)) begin
        ctrl_stage_q <= cfg.cfg_data[CTRL_W-1:0];
        ctrl_dirty_q <= 1'b1;
      end
      if (apply_go && ctrl_dirty_q) begin
        frac_byp_q   <= ctrl_stage_q[CTRL_FRAC_BYP];
        iir5m_byp_q  <= ctrl_stage_q[CTRL_IIR5M_BYP];
        iir24_byp_q  <= ctrl_stage_q[CTRL_IIR24_BYP];
        cic_byp_q    <= ctrl_stage_q[CTRL_CIC_BYP];
        // A zero decimation factor would stall the CIC, so it becomes 1
        dec_q        <= (dec_staged == '0) ? DEC_W'(1) : dec_staged;
        ctrl_dirty_q <= 1'b0;
      end
    end
  end

  assign frac_bypass     = frac_byp_q;
  assign iir_bypass_5m   = iir5m_byp_q;
  assign iir_bypass_2_4m = iir24_byp_q;
  assign cic_bypass      = cic_byp_q;
  assign cic_dec_factor  = dec_q;

  cfg_coeff_bank #(.COEFF_WIDTH(COEFF_WIDTH), .DEPTH(N_TAP), .BASE(FRAC_BASE)) u_frac (
    .clk(clk), .rst_n(rst_n), .wr_i(wr_acc), .addr_i(cfg.cfg_addr), .data_i(cfg.cfg_data),
    .apply_i(apply_go), .wr_en_o(frac_wr_en), .coeff_o(frac_coeff)
  );

  cfg_coeff_bank #(.COEFF_WIDTH(COEFF_WIDTH), .DEPTH(COEFF_DEPTH), .BASE(IIR1_BASE)) u_iir_1m (
    .clk(clk), .rst_n(rst_n), .wr_i(wr_acc), .addr_i(cfg.cfg_addr), .data_i(cfg.cfg_data),
    .apply_i(apply_go), .wr_en_o(iir_wr_en_1m), .coeff_o(iir_coeff_1m)
  );

  cfg_coeff_bank #(.COEFF_WIDTH(COEFF_WIDTH), .DEPTH(COEFF_DEPTH), .BASE(IIR2_BASE)) u_iir_2m (
    .clk(clk), .rst_n(rst_n), .wr_i(wr_acc), .addr_i(cfg.cfg_addr), .data_i(cfg.cfg_data),
    .apply_i(apply_go), .wr_en_o(iir_wr_en_2m), .coeff_o(iir_coeff_2m)
  );

  cfg_coeff_bank #(.COEFF_WIDTH(COEFF_WIDTH), .DEPTH(COEFF_DEPTH), .BASE(IIR24_BASE)) u_iir_2_4m (
    .clk(clk), .rst_n(rst_n), .wr_i(wr_acc), .addr_i(cfg.cfg_addr), .data_i(cfg.cfg_data),
    .apply_i(apply_go), .wr_en_o(iir_wr_en_2_4m), .coeff_o(iir_coeff_2_4m)
  );

endmodule

// File: tb/tb_dfe_cfg_sequencer.sv
// Randomized scoreboard bench for dfe_cfg_sequencer with an address-level reference model.
module tb_dfe_cfg_sequencer;
  import dfe_cfg_pkg::*;

  localparam int CW     = 20;
  localparam int NT     = 72;
  localparam int CD     = 5;
  localparam int DW     = 4;
  localparam int GAP    = 64;
  localparam int NWORDS = CTRL_ADDR;

  typedef struct packed {
    logic [3:0]           mask;
    logic                 late;
    logic                 err_before;
    logic [3:0]           byp;
    logic [DW:0]          dec;
    logic [31:0]          off;
    logic [NWORDS*CW-1:0] words;
  } exp_t;

  logic clk;
  logic rst_n;
  logic core_valid_in;
  logic commit_done, commit_late, addr_err;
  logic signed [CW-1:0] frac_coeff [NT];
  logic signed [CW-1:0] iir_coeff_1m [CD];
  logic signed [CW-1:0] iir_coeff_2m [CD];
  logic signed [CW-1:0] iir_coeff_2_4m [CD];
  logic frac_wr_en, iir_wr_en_1m, iir_wr_en_2m, iir_wr_en_2_4m;
  logic frac_bypass, iir_bypass_5m, iir_bypass_2_4m, cic_bypass;
  logic [DW:0] cic_dec_factor;

  dfe_cfg_sequencer_if #(.COEFF_WIDTH(CW)) cfg ();

  dfe_cfg_sequencer #(
    .COEFF_WIDTH(CW), .N_TAP(NT), .COEFF_DEPTH(CD), .DEC_WIDTH(DW), .GAP_TIMEOUT(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg), .core_valid_in(core_valid_in),
    .commit_done(commit_done), .commit_late(commit_late), .addr_err(addr_err),
    .frac_coeff(frac_coeff), .iir_coeff_1m(iir_coeff_1m), .iir_coeff_2m(iir_coeff_2m),
    .iir_coeff_2_4m(iir_coeff_2_4m),
    .frac_wr_en(frac_wr_en), .iir_wr_en_1m(iir_wr_en_1m), .iir_wr_en_2m(iir_wr_en_2m),
    .iir_wr_en_2_4m(iir_wr_en_2_4m),
    .frac_bypass(frac_bypass), .iir_bypass_5m(iir_bypass_5m), .iir_bypass_2_4m(iir_bypass_2_4m),
    .cic_bypass(cic_bypass), .cic_dec_factor(cic_dec_factor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic exp_t reset_rec();
    exp_t r;
    r       = '0;
    r.byp   = 4'hF;
    r.dec   = 1;
    return r;
  endfunction

  // 0..3 coefficient banks, 4 CTRL, 5 unmapped
  function automatic int bank_of(input int a);
    if (a < IIR1_BASE)  return 0;
    if (a < IIR2_BASE)  return 1;
    if (a < IIR24_BASE) return 2;
    if (a < CTRL_ADDR)  return 3;
    if (a == CTRL_ADDR) return 4;
    return 5;
  endfunction

  function automatic logic [CW-1:0] dut_word(input int a);
    if (a < IIR1_BASE)  return frac_coeff[a];
    if (a < IIR2_BASE)  return iir_coeff_1m[a - IIR1_BASE];
    if (a < IIR24_BASE) return iir_coeff_2m[a - IIR2_BASE];
    return iir_coeff_2_4m[a - IIR24_BASE];
  endfunction

  task automatic compare_outputs(input exp_t r, input string tag);
    for (int a = 0; a < NWORDS; a++)
      check($sformatf("%s_word%0d", tag, a), dut_word(a), r.words[a*CW +: CW]);
    check({tag, "_bypass"}, {cic_bypass, iir_bypass_2_4m, iir_bypass_5m, frac_bypass}, r.byp);
    check({tag, "_dec_factor"}, cic_dec_factor, r.dec);
  endtask

  // Reference model: staged words by address, dirty flag per bank, last applied image
  logic [CW-1:0] m_stg [NWORDS];
  logic [CW-1:0] m_ctrl;
  bit            m_dirty [5];
  bit            m_err;
  exp_t          m_applied;

  task automatic model_reset();
    for (int a = 0; a < NWORDS; a++) m_stg[a] = '0;
    for (int b = 0; b < 5; b++) m_dirty[b] = 1'b0;
    m_ctrl    = '0;
    m_err     = 1'b0;
    m_applied = reset_rec();
  endtask

  task automatic model_write(input int a, input logic [CW-1:0] d);
    int b;
    b = bank_of(a);
    if (b == 5) m_err = 1'b1;
    else if (b == 4) begin
      m_ctrl     = d;
      m_dirty[4] = 1'b1;
    end else begin
      m_stg[a]   = d;
      m_dirty[b] = 1'b1;
    end
  endtask

  // k = number of PENDING cycles during which the core keeps valid_in high
  task automatic model_commit(input int k, output exp_t r);
    logic [DW:0] dec;
    r = m_applied;
    r.mask = {m_dirty[3], m_dirty[2], m_dirty[1], m_dirty[0]};
    for (int a = 0; a < NWORDS; a++)
      if (m_dirty[bank_of(a)]) r.words[a*CW +: CW] = m_stg[a];
    if (m_dirty[4]) begin
      r.byp = m_ctrl[3:0];
      dec   = m_ctrl[8:4];
      r.dec = (dec == 0) ? 5'd1 : dec;
    end
    r.late       = (k >= GAP);
    r.off        = r.late ? 32'(GAP + 1) : 32'(k + 2);
    r.err_before = m_err;
    m_applied    = r;
    for (int b = 0; b < 5; b++) m_dirty[b] = 1'b0;
    m_err = 1'b0;
  endtask

  // Stimulus tasks start and end just after a rising edge
  task automatic wait_ready();
    int n;
    n = 0;
    while (!cfg.cfg_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cfg.cfg_ready) fail_now("ready_timeout", "cfg_ready stayed low for 500 cycles");
  endtask

  task automatic cfg_write(input int a, input logic [CW-1:0] d);
    wait_ready();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_addr  = 7'(a);
    cfg.cfg_data  = d;
    @(posedge clk); #1;
    cfg.cfg_valid = 1'b0;
    model_write(a, d);
  endtask

  task automatic cfg_commit_go(input int k, input bit with_wr, input int a, input logic [CW-1:0] d);
    exp_t r;
    int   last;
    wait_ready();
    if (with_wr) begin
      model_write(a, d);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_addr  = 7'(a);
      cfg.cfg_data  = d;
    end
    model_commit(k, r);
    exp_q.push_back(r);
    cfg.cfg_commit = 1'b1;
    core_valid_in  = 1'($urandom);
    @(posedge clk); #1;
    cfg.cfg_commit = 1'b0;
    cfg.cfg_valid  = 1'b0;
    last = (k < GAP) ? k + 1 : GAP + 1;
    for (int i = 1; i <= last; i++) begin
      core_valid_in = (i <= k);
      @(posedge clk); #1;
    end
    core_valid_in = 1'b0;
  endtask

  // Monitor: timestamps accepts and write enables, pops an expectation on every commit_done
  int   t = 0;
  int   acc_t = 0;
  int   wr_t = 0;
  int   wr_cnt [4];
  bit   in_rst = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    logic [3:0] wr;
    exp_t       rec;
    wr = {iir_wr_en_2_4m, iir_wr_en_2m, iir_wr_en_1m, frac_wr_en};
    t++;
    if (!rst_n) begin
      exp_q.delete();
      cur    = reset_rec();
      in_rst = 1'b1;
      for (int b = 0; b < 4; b++) wr_cnt[b] = 0;
      check("wr_en_in_reset", wr, 0);
    end else begin
      if (in_rst) begin
        in_rst = 1'b0;
        check("ready_after_reset", cfg.cfg_ready, 1);
        check("late_after_reset", commit_late, 0);
        check("addr_err_after_reset", addr_err, 0);
        check("done_after_reset", commit_done, 0);
        compare_outputs(cur, "reset");
      end
      if (cfg.cfg_commit && cfg.cfg_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_commit", "commit accepted with no expectation queued");
        else begin
          check("addr_err_at_commit", addr_err, exp_q[0].err_before);
          check("late_held_until_commit", commit_late, cur.late);
          compare_outputs(cur, "pre_apply");
        end
        acc_t = t;
        wr_t  = -100;
        for (int b = 0; b < 4; b++) wr_cnt[b] = 0;
      end
      if (wr != 0) begin
        check("wr_en_expected", exp_q.size() != 0, 1);
        for (int b = 0; b < 4; b++) if (wr[b]) wr_cnt[b]++;
        wr_t = t;
      end
      if (commit_done) begin
        if (exp_q.size() == 0) fail_now("unexpected_done", "commit_done with no expectation queued");
        else begin
          rec = exp_q.pop_front();
          check("done_latency", t - acc_t, rec.off + 1);
          for (int b = 0; b < 4; b++)
            check($sformatf("wr_en_count_bank%0d", b), wr_cnt[b], rec.mask[b]);
          if (rec.mask != 0) check("wr_en_before_done", t - wr_t, 1);
          check("commit_late", commit_late, rec.late);
          check("addr_err_cleared", addr_err, 0);
          compare_outputs(rec, "applied");
          cur = rec;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int k, nw, a;
    rst_n          = 1'b0;
    cfg.cfg_valid  = 1'b0;
    cfg.cfg_commit = 1'b0;
    cfg.cfg_addr   = '0;
    cfg.cfg_data   = '0;
    core_valid_in  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full fractional bank, gap available immediately
    for (int i = 0; i < NT; i++) cfg_write(i, CW'(i));
    cfg_commit_go(0, 1'b0, 0, '0);

    // One IIR 1 MHz word, core busy for 10 cycles
    cfg_write(73, 20'h12345);
    cfg_commit_go(10, 1'b0, 0, '0);

    // Empty commit with core never idle: forced apply
    cfg_commit_go(100, 1'b0, 0, '0);

    // CTRL word, then a zero decimation factor that must clamp to 1
    cfg_write(CTRL_ADDR, 20'h00035);
    cfg_commit_go(3, 1'b0, 0, '0);
    cfg_write(CTRL_ADDR, 20'h00000);
    cfg_write(84, 20'hFFFF0);
    cfg_commit_go(1, 1'b0, 0, '0);

    // Unmapped write, then empty commit
    cfg_write(90, 20'h0BEEF);
    cfg_commit_go(0, 1'b0, 0, '0);

    // Randomized rounds
    for (int it = 0; it < 25; it++) begin
      nw = $urandom_range(0, 12);
      for (int j = 0; j < nw; j++) cfg_write($urandom_range(0, 95), CW'($urandom));
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 6);
      a = $urandom_range(0, CTRL_ADDR);
      cfg_commit_go(k, 1'($urandom), a, CW'($urandom));
    end

    // Reset while PENDING: staged data and the pending commit are discarded
    cfg_write(5, 20'h0ABCD);
    cfg_write(CTRL_ADDR, 20'h00070);
    wait_ready();
    begin
      exp_t r;
      model_commit(200, r);
      exp_q.push_back(r);
    end
    cfg.cfg_commit = 1'b1;
    core_valid_in  = 1'b1;
    @(posedge clk); #1;
    cfg.cfg_commit = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    model_reset();
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    core_valid_in = 1'b0;
    cfg_commit_go(0, 1'b0, 0, '0);
    cfg_write(80, 20'h54321);
    cfg_commit_go(2, 1'b0, 0, '0);

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (exp_q.size() != 0) fail_now("drain_timeout", "expected commits never completed");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
